// File: rtl/mips_pkg.sv
// Shared MIPS datapath types: register-file geometry, word/address types, sweep FSM states.
package mips_pkg;

   localparam int REG_AW = 5;
   localparam int REG_W  = 32;
   localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

   typedef logic [REG_AW-1:0] reg_addr_t;
   typedef logic [REG_W-1:0]  word_t;

   typedef enum logic {
      SWEEP = 1'b0,
      READY = 1'b1
   } rf_state_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational register-file read path, zero latency, no flow control.
// Priority: busy gating, then $0, then same-cycle write forwarding, then array.
module rf_read_port
   import mips_pkg::*;
#(
   parameter int WIDTH = REG_W,
   parameter int AW    = REG_AW
) (
   input  logic             busy,
   input  logic [AW-1:0]    ra,
   input  logic             we,
   input  logic [AW-1:0]    wa,
   input  logic [WIDTH-1:0] wd,
   input  logic [WIDTH-1:0] regs [2**AW],
   output logic [WIDTH-1:0] rd
);

   logic zero_sel;
   logic fwd_sel;

   assign zero_sel = busy || (ra == '0);
   assign fwd_sel  = we && (wa != '0) && (wa == ra);

   always_comb begin
      rd = '0;
      if (!zero_sel) begin
         if (fwd_sel) begin
            rd = wd;
         end else begin
            rd = regs[ra];
         end
      end
   end

endmodule

// File: rtl/regfile_5addr.sv
// 32x32 MIPS register file: two async read ports, one sync write port, $0 hardwired to zero.
// After reset a one-register-per-cycle clear sweep runs with busy high; writes are dropped meanwhile.
module regfile_5addr
   import mips_pkg::*;
#(
   parameter int WIDTH = REG_W,
   parameter int AW    = REG_AW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    wa,
   input  logic [WIDTH-1:0] wd,
   input  logic [AW-1:0]    ra1,
   input  logic [AW-1:0]    ra2,
   output logic [WIDTH-1:0] rd1,
   output logic [WIDTH-1:0] rd2,
   output logic             busy
);

   localparam logic [AW-1:0] PTR_FIRST = AW'(1);
   localparam logic [AW-1:0] PTR_LAST  = {AW{1'b1}};

   rf_state_t        state;
   logic [AW-1:0]    ptr;
   logic [WIDTH-1:0] regs [2**AW];
   logic             wr_ok;

   // Entry 0 is never written; both read ports mask it out.
   assign wr_ok = (state == READY) && we && (wa != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SWEEP;
         ptr   <= PTR_FIRST;
         busy  <= 1'b1;
      end else if (state == SWEEP) begin
         regs[ptr] <= '0;
         ptr       <= ptr + 1'b1;
         if (ptr == PTR_LAST) begin
            state <= READY;
            busy  <= 1'b0;
         end
      end else if (wr_ok) begin
         regs[wa] <= wd;
      end
   end

   rf_read_port #(
      .WIDTH (WIDTH),
      .AW    (AW)
   ) u_rd1 (
      .busy (busy),
      .ra   (ra1),
      .we   (we),
      .wa   (wa),
      .wd   (wd),
      .regs (regs),
      .rd   (rd1)
   );

   rf_read_port #(
      .WIDTH (WIDTH),
      .AW    (AW)
   ) u_rd2 (
      .busy (busy),
      .ra   (ra2),
      .we   (we),
      .wa   (wa),
      .wd   (wd),
      .regs (regs),
      .rd   (rd2)
   );

endmodule

// File: tb/tb_regfile_5addr.sv
// Scoreboarded random/directed bench for regfile_5addr against a register-array model.
module tb_regfile_5addr;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we  = 1'b0;
   logic [4:0]  wa  = '0;
   logic [31:0] wd  = '0;
   logic [4:0]  ra1 = '0;
   logic [4:0]  ra2 = '0;
   logic [31:0] rd1;
   logic [31:0] rd2;
   logic        busy;

   always #5 clk = ~clk;

   regfile_5addr dut (
      .clk  (clk),
      .rst  (rst),
      .we   (we),
      .wa   (wa),
      .wd   (wd),
      .ra1  (ra1),
      .ra2  (ra2),
      .rd1  (rd1),
      .rd2  (rd2),
      .busy (busy)
   );

   int checks = 0;
   int errors = 0;

   // Model: architectural register contents plus "sweep edges remaining"
   logic [31:0] m [32];
   logic        mbusy  = 1'b1;
   int          left   = 0;
   bit          mvalid = 1'b0;

   typedef struct {
      logic        b;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [4:0]  a1;
      logic [4:0]  a2;
   } exp_t;
   exp_t q[$];
   exp_t e;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_rd(input logic [4:0] ra);
      if (mbusy || ra == 5'd0) return 32'h0;
      if (we && wa == ra) return wd;
      return m[ra];
   endfunction

   task automatic model_edge(input logic r, input logic w, input logic [4:0] a, input logic [31:0] d);
      if (r) begin
         mbusy  = 1'b1;
         left   = 31;
         mvalid = 1'b1;
      end else if (mvalid) begin
         if (mbusy) begin
            left--;
            if (left == 0) begin
               mbusy = 1'b0;
               for (int i = 1; i < 32; i++) m[i] = 32'h0;
            end
         end else if (w && a != 5'd0) begin
            m[a] = d;
         end
      end
   endtask

   task automatic step(input logic r, input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic [4:0] x1, input logic [4:0] x2);
      exp_t x;
      rst = r; we = w; wa = a; wd = d; ra1 = x1; ra2 = x2;
      if (mvalid) begin
         x.b  = mbusy;
         x.r1 = exp_rd(x1);
         x.r2 = exp_rd(x2);
         x.a1 = x1;
         x.a2 = x2;
         q.push_back(x);
      end
      @(posedge clk);
      model_edge(r, w, a, d);
      #1;
   endtask

   task automatic idle(input logic [4:0] x1, input logic [4:0] x2);
      step(1'b0, 1'b0, 5'd0, 32'h0, x1, x2);
   endtask

   // Runs with rst low until busy falls, firing writes that must all be dropped.
   task automatic sweep_count(input string nm);
      int n;
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         if (n == 9)
            step(1'b0, 1'b1, 5'd3, 32'h1234_5678, 5'($urandom), 5'($urandom));
         else if (n == 30)
            step(1'b0, 1'b1, 5'd5, 32'hCAFE_0005, 5'd5, 5'($urandom));
         else
            step(1'b0, 1'($urandom), 5'($urandom), $urandom, 5'($urandom), 5'($urandom));
         n++;
      end
      chk(nm, 32'(n), 32'd31);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("busy", {31'h0, busy}, {31'h0, e.b});
         chk($sformatf("rd1[ra=%0d]", e.a1), rd1, e.r1);
         chk($sformatf("rd2[ra=%0d]", e.a2), rd2, e.r2);
      end
   end

   initial begin
      logic [4:0]  a;
      logic [31:0] d;
      logic        r;

      step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      step(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
      sweep_count("sweep_len_first");
      for (int i = 1; i < 32; i++) idle(5'(i), 5'(32 - i));

      // plain write then read
      step(1'b0, 1'b1, 5'd17, 32'hDEAD_BEEF, 5'd0, 5'd0);
      idle(5'd17, 5'd16);

      // $0 write discarded, no forwarding either
      step(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
      idle(5'd0, 5'd0);

      // same-cycle forwarding over an older value
      step(1'b0, 1'b1, 5'd8, 32'h0000_1111, 5'd0, 5'd0);
      step(1'b0, 1'b1, 5'd8, 32'h0000_2222, 5'd8, 5'd8);
      idle(5'd8, 5'd8);

      // reset re-asserted in the middle of a sweep
      step(1'b1, 1'b0, 5'd0, 32'h0, 5'd8, 5'd17);
      for (int i = 0; i < 19; i++)
         step(1'b0, 1'($urandom), 5'($urandom), $urandom, 5'($urandom), 5'($urandom));
      step(1'b1, 1'b0, 5'd0, 32'h0, 5'd8, 5'd17);
      sweep_count("sweep_len_restart");
      idle(5'd8, 5'd17);

      // rst and write on the same edge in READY
      step(1'b0, 1'b1, 5'd31, 32'h0BAD_0031, 5'd0, 5'd0);
      step(1'b1, 1'b1, 5'd31, 32'hA5A5_A5A5, 5'd31, 5'd31);
      sweep_count("sweep_len_collision");
      idle(5'd31, 5'd31);

      for (int i = 0; i < 400; i++) begin
         r = ($urandom_range(0, 149) == 0);
         a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         d = $urandom;
         step(r, 1'($urandom), a, d,
              ($urandom_range(0, 2) == 0) ? a : 5'($urandom),
              ($urandom_range(0, 3) == 0) ? a : 5'($urandom));
      end

      @(negedge clk);
      #1;
      chk("scoreboard_drain", 32'(q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_5addr.md
Name: regfile_5addr

Overview:
- 32-entry x 32-bit MIPS register file: two asynchronous read ports, one synchronous write port.
- Write address is the 5-bit destination register selected by the datapath's 5-bit rt/rd mux; this block is the consumer end of that selection.
- Register $0 is hardwired to zero.
- After reset, a sequential clear sweep zeroes $1..$31 one register per cycle; `busy` is high while the sweep runs.

Parameters:
- WIDTH, 32, data width of each register.
- AW, 5, address width; number of registers = 2**AW.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- we  input  1  write enable.
- wa  input  AW  write register address (from the 5-bit destination mux).
- wd  input  WIDTH  write data.
- ra1  input  AW  read address, port 1.
- ra2  input  AW  read address, port 2.
- rd1  output  WIDTH  read data, port 1.
- rd2  output  WIDTH  read data, port 2.
- busy  output  1  clear sweep in progress; writes ignored and reads return 0 while high.

Behaviour:
- State machine: SWEEP, READY.
- Reset:
  - rst sampled high at a rising edge -> state=SWEEP, ptr=1, busy=1.
  - Register contents are not touched by rst itself.
  - rst held high keeps ptr at 1.
- SWEEP (rst low):
  - Each edge: reg[ptr] <= 0, ptr <= ptr+1.
  - The edge that clears reg[31] moves state to READY; busy=0 from that edge.
  - A full sweep is 31 edges after rst falls.
  - ptr is AW bits; there is no wrap past 31.
- Reset mid-sweep: restarts the sweep at ptr=1, busy stays 1.
- Reset in READY: returns to SWEEP at ptr=1.
- busy is registered and glitch-free. busy=1 out of reset; busy before the first reset is don't-care.
- Write, READY only: at a rising edge with we=1 and wa!=0 -> reg[wa] <= wd.
  - wa=0 writes are discarded.
  - we during SWEEP is ignored; no queuing.
- Read, combinational, zero latency:
  - busy=1 -> rd1=rd2=0.
  - ra=0 -> rd=0, regardless of bypass.
  - Else, if we=1, busy=0, wa!=0 and wa==ra -> rd=wd (write-through bypass, same-cycle forwarding).
  - Else rd=reg[ra].
  - Both ports are evaluated independently; the same address on both ports gives identical data.
- Simultaneous events:
  - rst and we on the same edge -> rst wins; the write is dropped.
  - A write on the final sweep edge is dropped, because busy is still 1 during that cycle.
- No X propagation: rd must never be X once busy has fallen, including for registers never written.

Decomposition:
- Shared package `mips_pkg`:
  - REG_AW=5, REG_W=32, REG_ZERO=5'd0.
  - typedef reg_addr_t (logic [4:0]), word_t (logic [31:0]).
  - enum rf_state_t {SWEEP, READY}.
- Sub-module `rf_read_port`: one combinational read path (busy gating, zero check, bypass compare, array select), instantiated twice.
- Sweep FSM and write logic stay in the top module.

Test Plan:
- Reset sweep: assert rst 2 cycles, release -> busy=1 for exactly 31 edges then 0; reading ra1=1..31 afterwards gives 32'h0000_0000 for every register.
- Basic write/read: we=1, wa=5'd17, wd=32'hDEAD_BEEF for one edge -> next cycle ra1=17 gives rd1=32'hDEAD_BEEF; ra2=16 gives 0.
- $0 protection: we=1, wa=0, wd=32'hFFFF_FFFF -> rd1 with ra1=0 stays 0, both in the same cycle (no bypass) and after the edge.
- Bypass: reg[8]=32'h0000_1111, then we=1, wa=8, wd=32'h0000_2222 with ra1=ra2=8 -> rd1=rd2=32'h0000_2222 in the same cycle, before the edge; after the edge with we=0 -> 32'h0000_2222.
- Write during sweep and mid-sweep reset:
  - we=1, wa=3, wd=32'h1234_5678 at sweep edge 10 -> dropped; reg3=0 after sweep.
  - Reassert rst at sweep edge 20 -> busy stays 1; after release, 31 further edges until busy=0.
- rst/we collision in READY: rst=1 and we=1, wa=31, wd=32'hA5A5_A5A5 on the same edge -> busy=1 next cycle; after the sweep, rd for ra=31 is 0.
